// File: rtl/display_scan_ctrl.sv
// Four-digit seven-segment scan controller with a double-buffered update port.
// Optional leading-zero blanking is enabled by defining DISPLAY_SCAN_LZB_EN.
module display_scan_ctrl #(
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned GUARD    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [15:0] upd_value,
  input  logic [3:0]  upd_dots,
  input  logic [3:0]  upd_blank,
  output logic [1:0]  dig_sel,
  output logic [3:0]  digit_val,
  output logic [3:0]  dots,
  output logic [3:0]  anodes,
  output logic        frame_tick
);

  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] PC_LAST  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] PC_GUARD = CW'(GUARD);

  typedef struct packed {
    logic [15:0] val;
    logic [3:0]  dp;
    logic [3:0]  blk;
  } disp_t;

  logic [CW-1:0] pcnt;
  logic [CW-1:0] pcnt_d;
  logic [1:0]    dig_d;
  disp_t         act_q;
  disp_t         act_d;
  disp_t         pend_q;
  disp_t         pend_d;
  logic          pend_valid;
  logic          pend_valid_d;
  logic          tc;
  logic          boundary;
  logic          accept;
  logic [3:0]    eb_d;
  logic [3:0]    anodes_d;

  // Effective per-digit blanking of a display set.
  function automatic logic [3:0] eff_blank(input disp_t d);
    logic [3:0] eb;
    eb = d.blk;
`ifdef DISPLAY_SCAN_LZB_EN
    if (d.val[15:4] == 12'h000) eb[1] = 1'b1;
    if (d.val[15:8] == 8'h00)   eb[2] = 1'b1;
    if (d.val[15:12] == 4'h0)   eb[3] = 1'b1;
`endif
    return eb;
  endfunction

  assign upd_ready = ~pend_valid;
  assign accept    = upd_valid & ~pend_valid;
  assign tc        = (pcnt == PC_LAST);
  assign boundary  = tc & (dig_sel == 2'd3);

  // Next-state: prescaler, digit step, pending/live swap, anode pattern.
  always_comb begin
    pcnt_d       = tc ? '0 : pcnt + CW'(1);
    dig_d        = tc ? dig_sel + 2'd1 : dig_sel;
    act_d        = act_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid;
    if (boundary && pend_valid) begin
      act_d        = pend_q;
      pend_valid_d = 1'b0;
    end else if (accept) begin
      pend_d       = '{val: upd_value, dp: upd_dots, blk: upd_blank};
      pend_valid_d = 1'b1;
    end
    eb_d     = eff_blank(act_d);
    anodes_d = 4'hF;
    if ((pcnt_d >= PC_GUARD) && !eb_d[dig_d]) anodes_d[dig_d] = 1'b0;
  end

  // Outputs are registered from next-state so digit, data and anode stay aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt       <= '0;
      dig_sel    <= '0;
      digit_val  <= '0;
      dots       <= '0;
      frame_tick <= 1'b0;
      anodes     <= 4'hF;
      act_q      <= '{val: 16'h0000, dp: 4'h0, blk: 4'hF};
      pend_q     <= '0;
      pend_valid <= 1'b0;
    end else begin
      pcnt       <= pcnt_d;
      dig_sel    <= dig_d;
      digit_val  <= act_d.val[{dig_d, 2'b00} +: 4];
      dots       <= act_d.dp;
      frame_tick <= boundary;
      anodes     <= anodes_d;
      act_q      <= act_d;
      pend_q     <= pend_d;
      pend_valid <= pend_valid_d;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl (PRESCALE=4, GUARD=1) against a
// time-indexed reference model; honours DISPLAY_SCAN_LZB_EN when defined.
module tb_display_scan_ctrl;

  localparam int PRESCALE = 4;
  localparam int GUARD    = 1;
  localparam int FRAME    = 4 * PRESCALE;

  typedef struct packed {
    logic [15:0] v;
    logic [3:0]  d;
    logic [3:0]  b;
  } upd_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        upd_valid = 1'b0;
  logic        upd_ready;
  logic [15:0] upd_value = '0;
  logic [3:0]  upd_dots = '0;
  logic [3:0]  upd_blank = '0;
  logic [1:0]  dig_sel;
  logic [3:0]  digit_val;
  logic [3:0]  dots;
  logic [3:0]  anodes;
  logic        frame_tick;
  logic [15:0] obs;

  int   tests = 0;
  int   fails = 0;
  int   t = 0;
  upd_t live;
  upd_t pend_q[$];

  display_scan_ctrl #(.PRESCALE(PRESCALE), .GUARD(GUARD)) dut (
    .clk(clk), .reset(reset), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_value(upd_value), .upd_dots(upd_dots), .upd_blank(upd_blank),
    .dig_sel(dig_sel), .digit_val(digit_val), .dots(dots), .anodes(anodes),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  assign obs = {dig_sel, digit_val, dots, anodes, frame_tick, upd_ready};

  // Expected outputs at cycle t: slot from t/PRESCALE, position from t%PRESCALE.
  function automatic logic [15:0] exp_vec();
    int         dig;
    int         pos;
    logic [3:0] eb;
    logic [3:0] an;
    logic [3:0] dv;
    dig = (t / PRESCALE) % 4;
    pos = t % PRESCALE;
    eb  = live.b;
`ifdef DISPLAY_SCAN_LZB_EN
    for (int n = 1; n < 4; n++) if ((live.v >> (4 * n)) == 16'h0) eb[n] = 1'b1;
`endif
    dv = 4'((live.v >> (4 * dig)) & 16'h000F);
    an = 4'hF;
    if (pos >= GUARD && !eb[dig]) an[dig] = 1'b0;
    return {2'(dig), dv, live.d, an, ((t % FRAME) == 0) && (t != 0), pend_q.size() == 0};
  endfunction

  // Advance one clock; the requester drops valid once its update is taken.
  task automatic tick();
    logic boundary;
    logic acc;
    boundary = (t % FRAME) == (FRAME - 1);
    acc      = upd_valid && (pend_q.size() == 0);
    @(posedge clk);
    #1;
    if (boundary && pend_q.size() != 0) begin
      live = pend_q.pop_front();
    end else if (acc) begin
      pend_q.push_back(upd_t'{upd_value, upd_dots, upd_blank});
      upd_valid = 1'b0;
    end
    t++;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    upd_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    t     = 0;
    live  = upd_t'{16'h0000, 4'h0, 4'hF};
    pend_q.delete();
  endtask

  task automatic offer(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    upd_value = v;
    upd_dots  = d;
    upd_blank = b;
    upd_valid = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (obs !== 16'h003D) begin
      fails++;
      $display("FAIL reset_state got %h exp %h", obs, 16'h003D);
    end
    while (t < 24) begin
      tests++;
      if (obs !== exp_vec()) begin
        fails++;
        $display("FAIL reset_scan t=%0d got %h exp %h", t, obs, exp_vec());
      end
      if (t == 16) begin
        tests++;
        if (frame_tick !== 1'b1 || anodes !== 4'hF) begin
          fails++;
          $display("FAIL reset_tick t=16 got tick=%b an=%b exp tick=1 an=1111", frame_tick, anodes);
        end
      end
      tick();
    end
  endtask

  task automatic test_update_scan();
    int k;
    do_reset();
    tick();
    tick();
    offer(16'h1234, 4'b0101, 4'b0000);
    while (t < 36) begin
      tests++;
      if (obs !== exp_vec()) begin
        fails++;
        $display("FAIL update_scan t=%0d got %h exp %h", t, obs, exp_vec());
      end
      if (t == 3) begin
        tests++;
        if (upd_ready !== 1'b0) begin
          fails++;
          $display("FAIL update_ready t=3 got %b exp 0", upd_ready);
        end
      end
      if (t >= 16 && t < 32) begin
        k = (t - 16) / 4;
        tests++;
        if (digit_val !== 4'(4 - k) || dots !== 4'b0101 ||
            anodes !== (((t % 4) == 0) ? 4'hF : ~(4'b0001 << k))) begin
          fails++;
          $display("FAIL update_frame2 t=%0d got dv=%h dots=%b an=%b exp dv=%h dots=0101",
                   t, digit_val, dots, anodes, 4'(4 - k));
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a;
    logic [15:0] b;
    a = 16'($urandom);
    b = 16'($urandom);
    do_reset();
    tick();
    offer(a, 4'($urandom), 4'b0000);
    tick();
    tick();
    offer(b, 4'($urandom), 4'b0000);
    while (t < 52) begin
      tests++;
      if (obs !== exp_vec()) begin
        fails++;
        $display("FAIL b2b t=%0d got %h exp %h", t, obs, exp_vec());
      end
      if (t == 10 || t == 16 || t == 17) begin
        tests++;
        if (upd_ready !== (t == 16)) begin
          fails++;
          $display("FAIL b2b_ready t=%0d got %b exp %b", t, upd_ready, t == 16);
        end
      end
      if (t == 20 || t == 36) begin
        tests++;
        if (digit_val !== ((t == 20) ? a[7:4] : b[7:4])) begin
          fails++;
          $display("FAIL b2b_data t=%0d got %h exp %h", t, digit_val,
                   (t == 20) ? a[7:4] : b[7:4]);
        end
      end
      tick();
    end
  endtask

  task automatic test_boundary_accept();
    logic [15:0] c;
    c = 16'($urandom);
    do_reset();
    while (t < 15) tick();
    offer(c, 4'b1111, 4'b0000);
    while (t < 36) begin
      tests++;
      if (obs !== exp_vec()) begin
        fails++;
        $display("FAIL boundary t=%0d got %h exp %h", t, obs, exp_vec());
      end
      if (t == 16 || t == 32) begin
        tests++;
        if (digit_val !== ((t == 16) ? 4'h0 : c[3:0]) || dots !== ((t == 16) ? 4'h0 : 4'hF)) begin
          fails++;
          $display("FAIL boundary_commit t=%0d got dv=%h dots=%b", t, digit_val, dots);
        end
      end
      tick();
    end
  endtask

  task automatic test_blank();
    logic [15:0] v;
    int          dg;
    v = 16'($urandom);
    do_reset();
    offer(v, 4'($urandom), 4'b1010);
    while (t < 36) begin
      tests++;
      if (obs !== exp_vec()) begin
        fails++;
        $display("FAIL blank t=%0d got %h exp %h", t, obs, exp_vec());
      end
      dg = (t / 4) % 4;
      if (t >= 16 && t < 32) begin
        tests++;
        if (dig_sel !== 2'(dg) || digit_val !== v[4*dg +: 4] ||
            ((dg == 1 || dg == 3) && anodes !== 4'hF)) begin
          fails++;
          $display("FAIL blank_mask t=%0d got sel=%0d dv=%h an=%b exp sel=%0d dv=%h",
                   t, dig_sel, digit_val, anodes, dg, v[4*dg +: 4]);
        end
      end
      tick();
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    tick();
    tick();
    offer(16'hBEEF, 4'b1001, 4'b0000);
    while (t < 7) tick();
    do_reset();
    tests++;
    if (obs !== 16'h003D) begin
      fails++;
      $display("FAIL mid_reset got %h exp %h", obs, 16'h003D);
    end
    while (t < 20) begin
      tests++;
      if (obs !== exp_vec() || (t == 16 && (digit_val !== 4'h0 || anodes !== 4'hF))) begin
        fails++;
        $display("FAIL mid_reset_after t=%0d got %h exp %h", t, obs, exp_vec());
      end
      tick();
    end
  endtask

`ifdef DISPLAY_SCAN_LZB_EN
  task automatic test_lzb();
    int dg;
    do_reset();
    offer(16'h0040, 4'b1111, 4'b0000);
    while (t < 64) begin
      if (t == 36) offer(16'h0000, 4'b1111, 4'b0000);
      tests++;
      if (obs !== exp_vec()) begin
        fails++;
        $display("FAIL lzb t=%0d got %h exp %h", t, obs, exp_vec());
      end
      dg = (t / 4) % 4;
      if (((t >= 16 && t < 32) || t >= 48) && (t % 4) != 0) begin
        tests++;
        if (anodes !== ((dg == 0 || (t < 32 && dg == 1)) ? ~(4'b0001 << dg) : 4'hF)) begin
          fails++;
          $display("FAIL lzb_anodes t=%0d got %b", t, anodes);
        end
      end
      tick();
    end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (i == 203) do_reset();
      if (!upd_valid && $urandom_range(0, 5) == 0)
        offer(16'($urandom), 4'($urandom), 4'($urandom_range(0, 15) & 4'($urandom)));
      tests++;
      if (obs !== exp_vec()) begin
        fails++;
        $display("FAIL random t=%0d got %h exp %h", t, obs, exp_vec());
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_update_scan();
    test_back_to_back();
    test_boundary_accept();
    test_blank();
    test_mid_reset();
`ifdef DISPLAY_SCAN_LZB_EN
    test_lzb();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

- Time-multiplexing controller for the four-digit seven-segment display.
- Steps the digit select through digits 0..3 at a programmable refresh rate.
- Per digit, drives the hex nibble to the segment decoder, the four dot bits and `dig_sel` to the dot-insertion stage, and one active-low anode enable.
- A valid/ready update port takes new display contents. A taken update is double-buffered and goes live only at a frame boundary, so no frame ever mixes old and new contents.

## Interface

Parameters:
- `PRESCALE`, default 50000: clock cycles per digit slot; legal range 2..65535.
- `GUARD`, default 16: anode-off cycles at the start of each slot (anti-ghosting); legal range 0..PRESCALE-1.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `upd_valid`  in  1  update request.
- `upd_ready`  out  1  update can be taken.
- `upd_value`  in  16  four hex digits; digit n is `[4n+3:4n]`.
- `upd_dots`  in  4  dot per digit.
- `upd_blank`  in  4  per-digit blank mask; 1 = digit dark.
- `dig_sel`  out  2  current digit index, to the dot-insertion stage.
- `digit_val`  out  4  hex nibble of the current digit, to the segment decoder.
- `dots`  out  4  live dot register, to the dot-insertion stage.
- `anodes`  out  4  active-low digit enables.
- `frame_tick`  out  1  one-cycle pulse when `dig_sel` wraps 3->0.

## Operation

- Prescaler `pcnt` counts 0..PRESCALE-1. At terminal count (`pcnt`=PRESCALE-1):
  - `pcnt` returns to 0 on the next edge;
  - `dig_sel` increments mod 4 on that edge.
- Frame boundary: the terminal-count cycle with `dig_sel`=3.
- Registers:
  - Live set: `act_value`, `act_dots`, `act_blank`.
  - Pending set: `pend_*` plus the flag `pend_valid`.
- `upd_ready` = !`pend_valid`, combinational from the flag.
- Accept = `upd_valid` && `upd_ready`. On accept, the update fields load into `pend_*` and `pend_valid` is set.
- At a frame boundary with `pend_valid`=1:
  - `pend_*` copies to `act_*`;
  - `pend_valid` clears.
  - The new contents are therefore live from the same edge that moves `dig_sel` to 0.
- Accept and a frame boundary in the same cycle:
  - If pending was already empty, the boundary commits nothing.
  - The accepted data sits in pending and commits at the next boundary.
- `upd_valid` is ignored while `upd_ready`=0. The requester holds its data until it sees ready.
- `digit_val` = `act_value` nibble selected by `dig_sel`. `dots` = `act_dots`.
- Digit n is dark when `eff_blank[n]`=1, where `eff_blank` = `act_blank` (see Configuration).
- `anodes` are registered. For `dig_sel`=n, `anodes[n]` is 0 only when:
  - `pcnt` >= GUARD, and
  - `eff_blank[n]`=0.
- All other anode bits stay 1.
- Reset mid-operation: all state returns to reset values on the next edge. Pending data is discarded.

## Timing

- Reset values:
  - `pcnt`=0, `dig_sel`=0, `digit_val`=0, `dots`=0, `frame_tick`=0;
  - `anodes`=4'b1111, `act_value`=0, `act_dots`=0, `act_blank`=4'b1111 (display dark);
  - `pend_valid`=0, so `upd_ready`=1.
- Slot length: PRESCALE cycles. Frame length: 4*PRESCALE cycles.
- `dig_sel`, `digit_val` and `dots` update on the same edge.
- `anodes` is registered from next-state `dig_sel`/`pcnt`, so it is cycle-aligned with `dig_sel`. No anode is ever low for the wrong digit.
- With GUARD=0, the anode is low for the full slot.
- `frame_tick` is high in the first cycle with `dig_sel`=0 after a wrap. It is not asserted on the first frame after reset.
- Update latency: from accept to live is 1 to 4*PRESCALE cycles. A second update is accepted one cycle after commit at the earliest.

## Configuration

- Macro: `DISPLAY_SCAN_LZB_EN`.
- Defined: leading-zero blanking.
  - `eff_blank[n]` = `act_blank[n]` OR (n>=1 AND nibbles n..3 of `act_value` all zero).
  - Digit 0 is never auto-blanked.
  - A blanked digit hides its dot, since its anode stays off.
- Undefined: `eff_blank` = `act_blank`; no extra logic.

## Test plan

All scenarios use PRESCALE=4, GUARD=1.

- Reset release:
  - `anodes` stays 4'b1111 with `upd_ready`=1.
  - `dig_sel` runs 0,0,0,0,1,1,1,1,2…
  - `frame_tick` pulses at cycle 16 after release.
- Update, then scan:
  - Stimulus: `upd_value`=16'h1234, `dots`=4'b0101, `blank`=0, accepted at cycle 2.
  - `upd_ready` drops at cycle 3.
  - Commit happens at the cycle-15 boundary. Frame 2 shows `digit_val` 4,3,2,1 with `anodes` 1110, 1101, 1011, 0111 (first slot cycle 1111).
  - `dots`=4'b0101 through frame 2.
- Back-pressure:
  - Second update presented with the first still pending: `upd_ready`=0 and the data is ignored.
  - It is accepted the cycle after commit and goes live one frame later.
- Accept on the boundary cycle: an update accepted exactly at the frame boundary goes live one frame later, not at that boundary.
- Blank mask:
  - Stimulus: `upd_blank`=4'b1010.
  - Digits 1 and 3 keep their anodes at 1 for the whole slot.
  - `dig_sel` and `digit_val` still sequence normally.
- With `DISPLAY_SCAN_LZB_EN`:
  - `upd_value`=16'h0040: digits 3 and 2 dark; digits 1 and 0 lit.
  - `upd_value`=0: only digit 0 lit.
  - Mid-frame `reset`: next-cycle `anodes`=4'b1111, `dig_sel`=0, `pend_valid`=0.
